// File: rtl/tile_pkg.sv
// Shared constants, FSM encodings and the draw-request record for the tile map scheduler.
package tile_pkg;
  localparam int TILE_PX    = 8;
  localparam int TILE_SHIFT = 3;
  localparam int TILE_WORDS = 64;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_READ_MAP   = 3'd1;
  localparam logic [2:0] S_ISSUE      = 3'd2;
  localparam logic [2:0] S_WAIT       = 3'd3;
  localparam logic [2:0] S_ADVANCE    = 3'd4;
  localparam logic [2:0] S_FRAME_DONE = 3'd5;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  x;
    logic [7:0]  y;
  } tile_req_t;

  // Pattern ROM start of a tile; wraps modulo 2^16.
  function automatic logic [15:0] tile_rom_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + idx * 16'(TILE_WORDS);
  endfunction
endpackage

// File: rtl/tile_map_cursor.sv
// Row-major col/row/linear-address walker over the tile map; holds at the last tile.
module tile_map_cursor #(
  parameter int MAP_W  = 20,
  parameter int MAP_H  = 15,
  parameter int MAP_AW = 9,
  parameter int COL_W  = $clog2(MAP_W),
  parameter int ROW_W  = $clog2(MAP_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              adv,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [MAP_AW-1:0] addr,
  output logic              last
);
  logic col_end, row_end;

  assign col_end = (col == COL_W'(MAP_W - 1));
  assign row_end = (row == ROW_W'(MAP_H - 1));
  assign last    = col_end && row_end;

  // Advancing past the last tile is suppressed so addr never leaves the map.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (adv && !last) begin
      if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      addr <= addr + 1'b1;
    end
  end
endmodule

// File: rtl/tile_map_scheduler.sv
// Walks the tile map once per frame and hands each tile to tile_drawer with a draw/done handshake.
// Build option: define SKIP_EMPTY_TILE_EN to skip map entries with index 0 (no draw pulse).
module tile_map_scheduler
  import tile_pkg::*;
#(
  parameter int          MAP_W       = 20,
  parameter int          MAP_H       = 15,
  parameter int          MAP_AW      = 9,
  parameter int          IDX_W       = 8,
  parameter logic [15:0] TILE_BASE   = 16'h0000,
  parameter int          MAP_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [MAP_AW-1:0] map_addr,
  input  logic [IDX_W-1:0]  map_rd_data,
  output logic [15:0]       tile_address,
  output logic [7:0]        x_out,
  output logic [7:0]        y_out,
  output logic              draw,
  input  logic              tile_done,
  output logic              busy,
  output logic              frame_done
);
  localparam int COL_W = $clog2(MAP_W);
  localparam int ROW_W = $clog2(MAP_H);
  localparam int WCW   = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;

  logic [2:0]       state;
  logic [WCW-1:0]   wait_cnt;
  logic [IDX_W-1:0] idx_q;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             cur_clear, cur_adv, cur_last, skip_idx;
  tile_req_t        req;

  assign cur_clear = (state == S_IDLE) && start;
  assign cur_adv   = (state == S_ADVANCE);

  tile_map_cursor #(
    .MAP_W (MAP_W),
    .MAP_H (MAP_H),
    .MAP_AW(MAP_AW),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_cursor (
    .clk  (clk),
    .reset(reset),
    .clear(cur_clear),
    .adv  (cur_adv),
    .col  (col),
    .row  (row),
    .addr (map_addr),
    .last (cur_last)
  );

  assign req.addr = tile_rom_addr(TILE_BASE, 16'(idx_q));
  assign req.x    = 8'(col) << TILE_SHIFT;
  assign req.y    = 8'(row) << TILE_SHIFT;

`ifdef SKIP_EMPTY_TILE_EN
  assign skip_idx = (map_rd_data == '0);
`else
  assign skip_idx = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      idx_q        <= '0;
      tile_address <= '0;
      x_out        <= '0;
      y_out        <= '0;
      draw         <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      draw       <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state    <= S_READ_MAP;
          wait_cnt <= '0;
          busy     <= 1'b1;
        end
        // map_addr is held steady while the RAM read completes.
        S_READ_MAP: if (wait_cnt == WCW'(MAP_LATENCY - 1)) begin
          idx_q <= map_rd_data;
          state <= skip_idx ? S_ADVANCE : S_ISSUE;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        S_ISSUE: begin
          draw         <= 1'b1;
          tile_address <= req.addr;
          x_out        <= req.x;
          y_out        <= req.y;
          state        <= S_WAIT;
        end
        S_WAIT: if (tile_done) state <= S_ADVANCE;
        S_ADVANCE: begin
          wait_cnt <= '0;
          if (cur_last) begin
            state      <= S_FRAME_DONE;
            frame_done <= 1'b1;
          end else begin
            state <= S_READ_MAP;
          end
        end
        S_FRAME_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
